// File: rtl/reg_writeback_ctrl.sv
// ---------------------------------------------------------------------------
// reg_writeback_ctrl
//
// Drives the write port of the 8x8 register file. It merges single-cycle ALU
// results and multi-cycle data-memory loads into registered one-cycle write
// strobes. It stalls the PC/decoder while a load is outstanding, aborts loads
// that hang past TIMEOUT cycles (setting a sticky ERR), and flags
// read-after-write forwarding for both register read ports.
//
// Ports:
//   CLK            system clock, all state updates on posedge
//   RESET          asynchronous active-low reset
//   ALU_VALID      ALU result valid this cycle (ignored while STALL)
//   ALU_RESULT     ALU result data
//   ALU_DEST       ALU destination register
//   LOAD_REQ       load issued this cycle (ignored while STALL)
//   LOAD_DEST      load destination register
//   MEM_BUSYWAIT   memory busy; low in LOAD_WAIT means MEM_READDATA is valid
//   MEM_READDATA   load data from memory
//   RD_ADDR1/2     addresses on the regfile read ports
//   ERR_CLR        clears ERR at the next edge
//   REG_IN         registered write data
//   REG_INADDRESS  registered write address
//   REG_WRITE      registered one-cycle write enable
//   STALL          hold PC/decoder (combinational)
//   FWD1_EN/2_EN   forward REG_IN in place of regfile OUT1/OUT2
//   ERR            sticky load-timeout flag
// ---------------------------------------------------------------------------
module reg_writeback_ctrl #(
    parameter int TIMEOUT = 16,
    parameter int CNT_W   = 8
) (
    input  logic       CLK,
    input  logic       RESET,
    input  logic       ALU_VALID,
    input  logic [7:0] ALU_RESULT,
    input  logic [2:0] ALU_DEST,
    input  logic       LOAD_REQ,
    input  logic [2:0] LOAD_DEST,
    input  logic       MEM_BUSYWAIT,
    input  logic [7:0] MEM_READDATA,
    input  logic [2:0] RD_ADDR1,
    input  logic [2:0] RD_ADDR2,
    input  logic       ERR_CLR,
    output logic [7:0] REG_IN,
    output logic [2:0] REG_INADDRESS,
    output logic       REG_WRITE,
    output logic       STALL,
    output logic       FWD1_EN,
    output logic       FWD2_EN,
    output logic       ERR
);

    typedef enum logic [1:0] {
        IDLE      = 2'd0,
        LOAD_WAIT = 2'd1,
        LOAD_WB   = 2'd2
    } state_t;

    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(TIMEOUT - 1);

    state_t           state_q;
    logic [CNT_W-1:0] cnt_q;
    logic [2:0]       dest_q;
    logic [7:0]       reg_in_q;
    logic [2:0]       reg_addr_q;
    logic             reg_write_q;
    logic             err_q;

    always_ff @(posedge CLK or negedge RESET) begin
        if (!RESET) begin
            state_q     <= IDLE;
            cnt_q       <= '0;
            dest_q      <= '0;
            reg_in_q    <= '0;
            reg_addr_q  <= '0;
            reg_write_q <= 1'b0;
            err_q       <= 1'b0;
        end else begin
            // Write enable is a pulse: it only survives an edge when a new
            // write is scheduled below. Data and address hold their values.
            reg_write_q <= 1'b0;

            // Clear first so that a timeout in the same cycle overrides it.
            if (ERR_CLR) begin
                err_q <= 1'b0;
            end

            case (state_q)
                IDLE: begin
                    // ALU and load may issue together: the load's write is at
                    // least two cycles away, so the ALU write cannot collide.
                    if (ALU_VALID) begin
                        reg_write_q <= 1'b1;
                        reg_in_q    <= ALU_RESULT;
                        reg_addr_q  <= ALU_DEST;
                    end
                    if (LOAD_REQ) begin
                        dest_q  <= LOAD_DEST;
                        cnt_q   <= '0;
                        state_q <= LOAD_WAIT;
                    end
                end
                LOAD_WAIT: begin
                    if (!MEM_BUSYWAIT) begin
                        reg_write_q <= 1'b1;
                        reg_in_q    <= MEM_READDATA;
                        reg_addr_q  <= dest_q;
                        state_q     <= LOAD_WB;
                    end else if (cnt_q == CNT_LAST) begin
                        // Hung load: abandon it without a write.
                        err_q   <= 1'b1;
                        state_q <= IDLE;
                    end else begin
                        cnt_q <= cnt_q + CNT_W'(1);
                    end
                end
                LOAD_WB: begin
                    state_q <= IDLE;
                end
                default: begin
                    state_q <= IDLE;
                end
            endcase
        end
    end

    // A load request stalls in its own issue cycle so the decoder holds the
    // following instruction until the controller is back in IDLE.
    assign STALL = (state_q != IDLE) || LOAD_REQ;

    // The regfile commits on the edge after REG_WRITE, so a read of the same
    // register during the pulse must take REG_IN directly.
    assign FWD1_EN = reg_write_q && (RD_ADDR1 == reg_addr_q);
    assign FWD2_EN = reg_write_q && (RD_ADDR2 == reg_addr_q);

    assign REG_IN        = reg_in_q;
    assign REG_INADDRESS = reg_addr_q;
    assign REG_WRITE     = reg_write_q;
    assign ERR           = err_q;

endmodule

// File: tb/tb_reg_writeback_ctrl.sv
// ---------------------------------------------------------------------------
// Testbench for reg_writeback_ctrl (TIMEOUT=4). The stimulus process pushes
// each expected register-file write (address, data, cycle) into a queue; a
// monitor on the falling edge pops and compares every REG_WRITE pulse.
// Status outputs (STALL, ERR, forwarding, reset values) are checked inline.
// ---------------------------------------------------------------------------
module tb_reg_writeback_ctrl;

    logic       CLK = 1'b0;
    logic       RESET;
    logic       ALU_VALID;
    logic [7:0] ALU_RESULT;
    logic [2:0] ALU_DEST;
    logic       LOAD_REQ;
    logic [2:0] LOAD_DEST;
    logic       MEM_BUSYWAIT;
    logic [7:0] MEM_READDATA;
    logic [2:0] RD_ADDR1;
    logic [2:0] RD_ADDR2;
    logic       ERR_CLR;
    logic [7:0] REG_IN;
    logic [2:0] REG_INADDRESS;
    logic       REG_WRITE;
    logic       STALL;
    logic       FWD1_EN;
    logic       FWD2_EN;
    logic       ERR;

    reg_writeback_ctrl #(.TIMEOUT(4), .CNT_W(8)) dut (
        .CLK(CLK), .RESET(RESET),
        .ALU_VALID(ALU_VALID), .ALU_RESULT(ALU_RESULT), .ALU_DEST(ALU_DEST),
        .LOAD_REQ(LOAD_REQ), .LOAD_DEST(LOAD_DEST),
        .MEM_BUSYWAIT(MEM_BUSYWAIT), .MEM_READDATA(MEM_READDATA),
        .RD_ADDR1(RD_ADDR1), .RD_ADDR2(RD_ADDR2), .ERR_CLR(ERR_CLR),
        .REG_IN(REG_IN), .REG_INADDRESS(REG_INADDRESS), .REG_WRITE(REG_WRITE),
        .STALL(STALL), .FWD1_EN(FWD1_EN), .FWD2_EN(FWD2_EN), .ERR(ERR)
    );

    always #5 CLK = ~CLK;

    typedef struct {
        logic [2:0] addr;
        logic [7:0] data;
        int         cyc;
    } exp_t;

    exp_t exp_q[$];
    int   checks   = 0;
    int   failures = 0;
    int   cyc_cnt  = 0;

    always @(posedge CLK) cyc_cnt <= cyc_cnt + 1;

    function automatic void check(string name, logic [31:0] act, logic [31:0] req);
        checks++;
        if (act !== req) begin
            failures++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h (cycle %0d)", name, act, req, cyc_cnt);
        end
    endfunction

    // Monitor: every write pulse must match the oldest expected write.
    always @(negedge CLK) begin
        if (RESET === 1'b1 && REG_WRITE === 1'b1) begin
            if (exp_q.size() == 0) begin
                checks++;
                failures++;
                $display("FAIL unexpected_write: addr=%0d data=0x%0h at cycle %0d, none expected",
                         REG_INADDRESS, REG_IN, cyc_cnt);
            end else begin
                exp_t e;
                e = exp_q.pop_front();
                check("wr_addr", 32'(REG_INADDRESS), 32'(e.addr));
                check("wr_data", 32'(REG_IN), 32'(e.data));
                check("wr_cycle", 32'(cyc_cnt), 32'(e.cyc));
            end
        end
    end

    task automatic tick();
        @(posedge CLK);
        #1;
    endtask

    task automatic expect_write(logic [2:0] a, logic [7:0] d, int c);
        exp_t e;
        e.addr = a;
        e.data = d;
        e.cyc  = c;
        exp_q.push_back(e);
    endtask

    task automatic idle_inputs();
        ALU_VALID = 1'b0;
        LOAD_REQ  = 1'b0;
        ERR_CLR   = 1'b0;
    endtask

    initial begin
        int c0;
        RESET = 1'b0;
        ALU_VALID = 1'b0; ALU_RESULT = 8'h00; ALU_DEST = 3'd0;
        LOAD_REQ = 1'b0; LOAD_DEST = 3'd0;
        MEM_BUSYWAIT = 1'b1; MEM_READDATA = 8'h00;
        RD_ADDR1 = 3'd0; RD_ADDR2 = 3'd0; ERR_CLR = 1'b0;

        // Reset state
        tick(); tick();
        check("rst_reg_write", 32'(REG_WRITE), 32'd0);
        check("rst_reg_in", 32'(REG_IN), 32'd0);
        check("rst_reg_addr", 32'(REG_INADDRESS), 32'd0);
        check("rst_err", 32'(ERR), 32'd0);
        check("rst_stall", 32'(STALL), 32'd0);
        RESET = 1'b1;
        tick();

        // ALU write with forwarding on port 1
        ALU_VALID = 1'b1; ALU_RESULT = 8'h5A; ALU_DEST = 3'd3;
        RD_ADDR1 = 3'd3; RD_ADDR2 = 3'd4;
        expect_write(3'd3, 8'h5A, cyc_cnt + 1);
        tick();
        idle_inputs();
        #1;
        check("alu_fwd1", 32'(FWD1_EN), 32'd1);
        check("alu_fwd2", 32'(FWD2_EN), 32'd0);
        tick();
        check("alu_pulse_end", 32'(REG_WRITE), 32'd0);
        check("alu_fwd1_end", 32'(FWD1_EN), 32'd0);
        check("alu_data_hold", 32'(REG_IN), 32'h5A);

        // Load with 3 busy cycles; ALU issue during the stall is ignored
        LOAD_REQ = 1'b1; LOAD_DEST = 3'd6; MEM_BUSYWAIT = 1'b1;
        c0 = cyc_cnt;
        #1;
        check("ld_stall_req", 32'(STALL), 32'd1);
        tick();
        LOAD_REQ = 1'b0;
        ALU_VALID = 1'b1; ALU_RESULT = 8'hEE; ALU_DEST = 3'd5;
        for (int i = 0; i < 3; i++) begin
            #1;
            check("ld_stall_busy", 32'(STALL), 32'd1);
            tick();
        end
        MEM_BUSYWAIT = 1'b0; MEM_READDATA = 8'hC3;
        expect_write(3'd6, 8'hC3, c0 + 5);
        #1;
        check("ld_stall_last", 32'(STALL), 32'd1);
        tick();
        check("ld_stall_wb", 32'(STALL), 32'd1);
        MEM_BUSYWAIT = 1'b1;
        tick();
        ALU_VALID = 1'b0;
        #1;
        check("ld_stall_done", 32'(STALL), 32'd0);
        tick();

        // Minimum-latency load: write at cycle 2, STALL low at cycle 3
        LOAD_REQ = 1'b1; LOAD_DEST = 3'd7; MEM_BUSYWAIT = 1'b0; MEM_READDATA = 8'h3C;
        expect_write(3'd7, 8'h3C, cyc_cnt + 2);
        tick();
        LOAD_REQ = 1'b0;
        tick();
        check("min_stall_c2", 32'(STALL), 32'd1);
        tick();
        check("min_stall_c3", 32'(STALL), 32'd0);
        tick();

        // Simultaneous ALU + load issue
        ALU_VALID = 1'b1; ALU_RESULT = 8'h11; ALU_DEST = 3'd1;
        LOAD_REQ = 1'b1; LOAD_DEST = 3'd2; MEM_BUSYWAIT = 1'b1;
        expect_write(3'd1, 8'h11, cyc_cnt + 1);
        expect_write(3'd2, 8'h22, cyc_cnt + 3);
        tick();
        idle_inputs();
        tick();
        MEM_BUSYWAIT = 1'b0; MEM_READDATA = 8'h22;
        tick();
        MEM_BUSYWAIT = 1'b1;
        tick();
        tick();

        // Timeout: 4 busy LOAD_WAIT cycles, then ERR and STALL drops
        LOAD_REQ = 1'b1; LOAD_DEST = 3'd5; MEM_BUSYWAIT = 1'b1;
        tick();
        LOAD_REQ = 1'b0;
        tick(); tick(); tick();
        check("to_err_before", 32'(ERR), 32'd0);
        check("to_stall_before", 32'(STALL), 32'd1);
        tick();
        check("to_err_set", 32'(ERR), 32'd1);
        check("to_stall_drop", 32'(STALL), 32'd0);
        ERR_CLR = 1'b1;
        tick();
        ERR_CLR = 1'b0;
        check("to_err_clr", 32'(ERR), 32'd0);

        // Second timeout, then a third with ERR_CLR on its timeout cycle
        LOAD_REQ = 1'b1;
        tick();
        LOAD_REQ = 1'b0;
        tick(); tick(); tick(); tick();
        check("to2_err_set", 32'(ERR), 32'd1);
        LOAD_REQ = 1'b1;
        tick();
        LOAD_REQ = 1'b0;
        tick(); tick();
        check("to3_err_sticky", 32'(ERR), 32'd1);
        tick();
        ERR_CLR = 1'b1;
        tick();
        ERR_CLR = 1'b0;
        check("to3_set_wins", 32'(ERR), 32'd1);

        // Reset mid-load: outputs clear at once, no write after release
        LOAD_REQ = 1'b1; LOAD_DEST = 3'd4; MEM_BUSYWAIT = 1'b1;
        tick();
        LOAD_REQ = 1'b0;
        tick();
        RESET = 1'b0;
        #1;
        check("mid_rst_err", 32'(ERR), 32'd0);
        check("mid_rst_reg_in", 32'(REG_IN), 32'd0);
        check("mid_rst_addr", 32'(REG_INADDRESS), 32'd0);
        check("mid_rst_stall", 32'(STALL), 32'd0);
        tick();
        RESET = 1'b1;
        MEM_BUSYWAIT = 1'b0; MEM_READDATA = 8'h99;
        tick(); tick(); tick(); tick();
        check("mid_rst_no_write", 32'(REG_WRITE), 32'd0);
        check("mid_rst_idle", 32'(STALL), 32'd0);

        tick();
        check("pending_writes", 32'(exp_q.size()), 32'd0);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

    initial begin
        #20000;
        $display("FAIL watchdog: simulation did not end, cycle %0d", cyc_cnt);
        $fatal(1, "watchdog");
    end

endmodule
